// File: rtl/run_speed_ctrl_if.sv
// Button pins and control outputs of run_speed_ctrl.
// The DUT connects through the slave modport and the button driver through the master modport.
interface run_speed_ctrl_if;
    logic       pause_btn;
    logic       slower_btn;
    logic       faster_btn;
    logic       tick;
    logic       running;
    logic [2:0] speed_level;
    logic [2:0] press;
    logic       state_dbg;

    modport master (
        output pause_btn, slower_btn, faster_btn,
        input  tick, running, speed_level, press, state_dbg
    );
    modport slave (
        input  pause_btn, slower_btn, faster_btn,
        output tick, running, speed_level, press, state_dbg
    );
endinterface

// File: rtl/run_speed_ctrl.sv
// Run/pause, speed level and tick prescaler for the running-pattern datapath.
// Debouncers are built only when RUN_SPEED_CTRL_DEBOUNCE_EN is defined; otherwise the synchronized level is used directly.
module run_speed_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BASE_PERIOD     = 781250,
    parameter int RESET_LEVEL     = 3
) (
    input  logic            clk,
    input  logic            rst,
    run_speed_ctrl_if.slave bus
);
    localparam int PW = $clog2(BASE_PERIOD) + 7;

    typedef enum logic {
        ST_PAUSED = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    if (DEBOUNCE_CYCLES < 2 || BASE_PERIOD < 2 || RESET_LEVEL < 0 || RESET_LEVEL > 7) begin : g_param_check
        $error("run_speed_ctrl: parameter out of range");
    end

    logic [2:0]    w_raw;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    w_deb;
    logic [2:0]    r_deb_d;
    logic [2:0]    r_press;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_level;
    logic [2:0]    w_level_nxt;
    logic          w_level_chg;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic [PW-1:0] w_period_last;
    logic          w_tick;

    assign w_raw = {bus.faster_btn, bus.slower_btn, bus.pause_btn};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef RUN_SPEED_CTRL_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [2:0]    r_deb;
    logic [DW-1:0] r_stable_cnt [3];

    // A level is accepted only after it has differed from the debounced level for DEBOUNCE_CYCLES edges in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb <= '0;
            for (int i = 0; i < 3; i++) r_stable_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_stable_cnt[i] <= '0;
                end else if (r_stable_cnt[i] == DEB_LAST) begin
                    r_deb[i]        <= r_sync2[i];
                    r_stable_cnt[i] <= '0;
                end else begin
                    r_stable_cnt[i] <= r_stable_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign w_deb = r_deb;
`else
    assign w_deb = r_sync2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_d <= '0;
            r_press <= '0;
        end else begin
            r_deb_d <= w_deb;
            r_press <= w_deb & ~r_deb_d;
        end
    end

    assign w_period_last = (PW'(BASE_PERIOD) << r_level) - PW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_level_chg = 1'b0;
        w_tick      = 1'b0;
        w_presc_nxt = r_presc;

        if (r_press[0]) begin
            case (r_state)
                ST_PAUSED: w_state_nxt = ST_RUN;
                ST_RUN:    w_state_nxt = ST_PAUSED;
                default:   w_state_nxt = ST_PAUSED;
            endcase
        end

        // Opposing presses cancel; saturated presses change nothing and keep the prescaler phase.
        if (r_press[1] && !r_press[2] && r_level != 3'd7) begin
            w_level_nxt = r_level + 3'd1;
            w_level_chg = 1'b1;
        end else if (r_press[2] && !r_press[1] && r_level != 3'd0) begin
            w_level_nxt = r_level - 3'd1;
            w_level_chg = 1'b1;
        end

        if (w_level_chg) begin
            w_presc_nxt = '0;
        end else if (r_state == ST_RUN) begin
            if (r_presc == w_period_last) begin
                w_tick      = 1'b1;
                w_presc_nxt = '0;
            end else begin
                w_presc_nxt = r_presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_PAUSED;
            r_level <= 3'(RESET_LEVEL);
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    assign bus.tick        = w_tick;
    assign bus.running     = (r_state == ST_RUN);
    assign bus.speed_level = r_level;
    assign bus.press       = r_press;
    assign bus.state_dbg   = r_state;
endmodule

// File: tb/tb_run_speed_ctrl.sv
// Directed bench for run_speed_ctrl with DEBOUNCE_CYCLES=4, BASE_PERIOD=4, RESET_LEVEL=3.
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_run_speed_ctrl;
    localparam int DEB  = 4;
    localparam int BASE = 4;
    localparam int RL   = 3;
`ifdef RUN_SPEED_CTRL_DEBOUNCE_EN
    localparam int LAT = DEB + 2;
`else
    localparam int LAT = 2;
`endif
    // Falling edges from the one where a button is raised to the one where press is visible.
    localparam int PIDX = LAT + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [2:0] exp_q[$];

    run_speed_ctrl_if bus();

    run_speed_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .BASE_PERIOD    (BASE),
        .RESET_LEVEL    (RL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_btn(input logic [2:0] mask);
        bus.pause_btn  = mask[0];
        bus.slower_btn = mask[1];
        bus.faster_btn = mask[2];
    endtask

    // Raises the buttons in mask, checks the press pulse, releases them; returns on the press cycle.
    task automatic press_btn(input logic [2:0] mask, input string tag);
        set_btn(mask);
        repeat (PIDX) @(negedge clk);
        check_eq(tag, {29'd0, bus.press}, {29'd0, mask});
        set_btn(3'b000);
    endtask

    // Falling edges until tick is seen; max+1 when it never comes.
    task automatic wait_tick(input int max, output int n);
        bit found;
        found = 1'b0;
        n = max + 1;
        for (int i = 1; i <= max; i++) begin
            if (!found) begin
                @(negedge clk);
                if (bus.tick === 1'b1) begin
                    found = 1'b1;
                    n = i;
                end
            end
        end
    endtask

    task automatic count_ticks(input int cycles, output int c);
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.tick !== 1'b0) c++;
        end
    endtask

    task automatic settle();
        repeat (LAT + 4) @(negedge clk);
    endtask

    initial begin
        int n;
        int c;
        int np;
        int pidx;
        logic [2:0] exp_lvl;

        set_btn(3'b000);

        // Reset asserted between clock edges takes effect at once.
        #2 rst = 1'b1;
        #1;
        check_eq("rst_tick", {31'd0, bus.tick}, 0);
        check_eq("rst_running", {31'd0, bus.running}, 0);
        check_eq("rst_level", {29'd0, bus.speed_level}, RL);
        check_eq("rst_press", {29'd0, bus.press}, 0);
        check_eq("rst_state", {31'd0, bus.state_dbg}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        count_ticks(100, c);
        check_eq("idle_ticks", c, 0);
        check_eq("idle_running", {31'd0, bus.running}, 0);

        // Pause button: bounces rejected (debounce build) or a one-cycle glitch accepted (bypass build).
        np = 0;
        pidx = 0;
`ifdef RUN_SPEED_CTRL_DEBOUNCE_EN
        for (int p = 0; p < 3; p++) begin
            set_btn(3'b001);
            repeat (3) begin
                @(negedge clk);
                if (bus.press[0] === 1'b1) np++;
            end
            set_btn(3'b000);
            repeat (3) begin
                @(negedge clk);
                if (bus.press[0] === 1'b1) np++;
            end
        end
`endif
        set_btn(3'b001);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
`ifndef RUN_SPEED_CTRL_DEBOUNCE_EN
            if (i == 1) set_btn(3'b000);
`endif
            if (bus.press[0] === 1'b1) begin
                np++;
                pidx = i;
            end
            if (i == PIDX) check_eq("running_before_update", {31'd0, bus.running}, 0);
            if (i == PIDX + 1) check_eq("running_after_press", {31'd0, bus.running}, 1);
        end
        set_btn(3'b000);
        check_eq("pause_press_count", np, 1);
        check_eq("pause_press_latency", pidx, PIDX);
        wait_tick(100, n);
        check_eq("first_tick_l3", (10 - PIDX) + n, 32);

        wait_tick(100, n);
        check_eq("tick_period_l3", n, 32);

        press_btn(3'b010, "press_slower");
        wait_tick(200, n);
        check_eq("tick_after_slower", n, 64);
        check_eq("level_after_slower", {29'd0, bus.speed_level}, 4);
        wait_tick(200, n);
        check_eq("tick_period_l4", n, 64);

        // Opposing presses right after a tick: counter keeps running from where it was.
        press_btn(3'b110, "press_both");
        wait_tick(200, n);
        check_eq("tick_after_both", n, 63 - LAT);
        check_eq("level_after_both", {29'd0, bus.speed_level}, 4);

        press_btn(3'b100, "press_faster");
        wait_tick(100, n);
        check_eq("tick_after_faster", n, 32);
        check_eq("level_after_faster", {29'd0, bus.speed_level}, 3);

        // Pause lands with the counter at 10; resume must finish the remaining 21 counts.
        repeat (9 - LAT) @(negedge clk);
        press_btn(3'b001, "press_pause");
        @(negedge clk);
        check_eq("paused_running", {31'd0, bus.running}, 0);
        count_ticks(40, c);
        check_eq("paused_ticks", c, 0);
        press_btn(3'b001, "press_resume");
        wait_tick(100, n);
        check_eq("tick_after_resume", n, 22);
        check_eq("resumed_running", {31'd0, bus.running}, 1);

        exp_lvl = 3'd3;
        for (int i = 0; i < 6; i++) begin
            exp_lvl = (exp_lvl == 3'd0) ? 3'd0 : exp_lvl - 3'd1;
            exp_q.push_back(exp_lvl);
        end
        for (int i = 0; i < 6; i++) begin
            press_btn(3'b100, "press_faster_sat");
            settle();
            check_eq("level_faster_sat", {29'd0, bus.speed_level}, {29'd0, exp_q.pop_front()});
        end
        wait_tick(20, n);
        wait_tick(20, n);
        check_eq("tick_period_l0", n, 4);

        for (int i = 0; i < 9; i++) begin
            exp_lvl = (exp_lvl == 3'd7) ? 3'd7 : exp_lvl + 3'd1;
            exp_q.push_back(exp_lvl);
        end
        for (int i = 0; i < 9; i++) begin
            press_btn(3'b010, "press_slower_sat");
            settle();
            check_eq("level_slower_sat", {29'd0, bus.speed_level}, {29'd0, exp_q.pop_front()});
        end
        wait_tick(600, n);
        wait_tick(600, n);
        check_eq("tick_period_l7", n, 512);

        // Reset in the middle of a clock period while running at level 7.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("midrst_tick", {31'd0, bus.tick}, 0);
        check_eq("midrst_running", {31'd0, bus.running}, 0);
        check_eq("midrst_level", {29'd0, bus.speed_level}, RL);
        check_eq("midrst_press", {29'd0, bus.press}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_ticks(50, c);
        check_eq("post_rst_ticks", c, 0);
        check_eq("post_rst_level", {29'd0, bus.speed_level}, RL);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
